// File: rtl/hex_score_msg_pkg.sv
// Shared constants for the paddle-game score/message display: letter codes,
// game states and the scrolling attract-mode message.
package hex_score_msg_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned MSG_LEN = 12;

    localparam logic [CODE_W-1:0] C_P  = 4'd0;
    localparam logic [CODE_W-1:0] C_A  = 4'd1;
    localparam logic [CODE_W-1:0] C_D  = 4'd2;
    localparam logic [CODE_W-1:0] C_L  = 4'd3;
    localparam logic [CODE_W-1:0] C_E  = 4'd4;
    localparam logic [CODE_W-1:0] C_U  = 4'd5;
    localparam logic [CODE_W-1:0] C_R  = 4'd6;
    localparam logic [CODE_W-1:0] C_B  = 4'd7;
    localparam logic [CODE_W-1:0] C_SP = 4'd8;
    localparam logic [CODE_W-1:0] C_V  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // "PADDLE BALL " as a ring of letter codes
    localparam logic [0:MSG_LEN-1][CODE_W-1:0] MSG_ROM = {
        C_P, C_A, C_D, C_D, C_L, C_E, C_SP, C_B, C_A, C_L, C_L, C_SP
    };

    // Letter at ring position (idx + off) mod 12; idx <= 11, off <= 5
    function automatic logic [CODE_W-1:0] msg_at(input logic [3:0] idx,
                                                 input logic [3:0] off);
        logic [4:0] pos;
        pos = 5'(idx) + 5'(off);
        if (pos >= 5'(MSG_LEN))
            pos = pos - 5'(MSG_LEN);
        return MSG_ROM[pos[3:0]];
    endfunction

endpackage

// File: rtl/hex_score_msg_bcd.sv
// Two-digit BCD score counter that saturates at 99.
module bcd_counter_2d
    import hex_score_msg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic at_max;
    assign at_max = (tens == 4'd9) && (ones == 4'd9);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc && !at_max) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/hex_score_msg.sv
// Six-digit display controller: scrolling attract message, live score/lives
// during play, and a DEAD + final score screen at game over.
module hex_score_msg
    import hex_score_msg_pkg::*;
#(
    parameter int INIT_LIVES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       tick,
    output logic [3:0] hex5,
    output logic [3:0] hex4,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [5:0] num_sel,
    output logic       game_over
);

    localparam logic [3:0] LIVES0 = 4'(INIT_LIVES);

    state_t     state, state_d;
    logic [3:0] idx, idx_d;
    logic [3:0] lives, lives_d;
    logic       clear, inc;
    logic [3:0] tens, ones;

    logic [3:0] hex5_d, hex4_d, hex3_d, hex2_d, hex1_l_d, hex0_l_d;
    logic [3:0] hex1_l, hex0_l;
    logic [5:0] num_sel_d;
    logic       game_over_d;

    bcd_counter_2d u_score (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (inc),
        .tens  (tens),
        .ones  (ones)
    );

    // Next-state logic; miss wins over hit, start wins over tick
    always_comb begin
        state_d = state;
        idx_d   = idx;
        lives_d = lives;
        clear   = 1'b0;
        inc     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    lives_d = LIVES0;
                    clear   = 1'b1;
                end else if (tick) begin
                    idx_d = (idx == 4'(MSG_LEN - 1)) ? 4'd0 : idx + 4'd1;
                end
            end
            PLAY: begin
                if (miss) begin
                    lives_d = lives - 4'd1;
                    if (lives == 4'd1)
                        state_d = OVER;
                end else if (hit) begin
                    inc = 1'b1;
                end
            end
            OVER: begin
                if (start) begin
                    state_d = PLAY;
                    lives_d = LIVES0;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display decode from the next state so outputs land one cycle after the event
    always_comb begin
        hex5_d      = msg_at(idx_d, 4'd0);
        hex4_d      = msg_at(idx_d, 4'd1);
        hex3_d      = msg_at(idx_d, 4'd2);
        hex2_d      = msg_at(idx_d, 4'd3);
        hex1_l_d    = msg_at(idx_d, 4'd4);
        hex0_l_d    = msg_at(idx_d, 4'd5);
        num_sel_d   = 6'b000000;
        game_over_d = 1'b0;
        case (state_d)
            PLAY: begin
                hex5_d    = C_L;
                hex4_d    = lives_d;
                hex3_d    = C_SP;
                hex2_d    = C_SP;
                num_sel_d = 6'b010011;
            end
            OVER: begin
                hex5_d      = C_D;
                hex4_d      = C_E;
                hex3_d      = C_A;
                hex2_d      = C_D;
                num_sel_d   = 6'b000011;
                game_over_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            lives     <= LIVES0;
            hex5      <= C_P;
            hex4      <= C_A;
            hex3      <= C_D;
            hex2      <= C_D;
            hex1_l    <= C_L;
            hex0_l    <= C_E;
            num_sel   <= 6'b000000;
            game_over <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            lives     <= lives_d;
            hex5      <= hex5_d;
            hex4      <= hex4_d;
            hex3      <= hex3_d;
            hex2      <= hex2_d;
            hex1_l    <= hex1_l_d;
            hex0_l    <= hex0_l_d;
            num_sel   <= num_sel_d;
            game_over <= game_over_d;
        end
    end

    // Low digits select between the message letters and the counter's score registers
    assign hex1 = num_sel[1] ? tens : hex1_l;
    assign hex0 = num_sel[0] ? ones : hex0_l;

endmodule
